// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multi-cycle RV32I controller and its shared-ALU datapath.
// The controller uses the master modport; the datapath/memory side uses the slave modport.
interface multicycle_ctrl_fsm_if;
  logic [6:0] i_op;
  logic [2:0] i_func_3;
  logic       i_func_7_5;
  logic       i_zero_flag;
  logic       i_negative_flag;
  logic       i_carry_flag;
  logic       i_overflow_flag;
  logic       i_mem_ready;
  logic [1:0] o_alu_op;
  logic [1:0] o_result_src;
  logic [1:0] o_alu_src_1;
  logic [1:0] o_alu_src_2;
  logic [2:0] o_imm_src;
  logic       o_mem_addr_src;
  logic       o_mem_req;
  logic       o_mem_write_en;
  logic       o_instr_write_en;
  logic       o_reg_write_en;
  logic       o_pc_update;
  logic       o_trap;
  logic [1:0] o_trap_cause;

  modport master (
    input  i_op, i_func_3, i_func_7_5, i_zero_flag, i_negative_flag,
           i_carry_flag, i_overflow_flag, i_mem_ready,
    output o_alu_op, o_result_src, o_alu_src_1, o_alu_src_2, o_imm_src,
           o_mem_addr_src, o_mem_req, o_mem_write_en, o_instr_write_en,
           o_reg_write_en, o_pc_update, o_trap, o_trap_cause
  );

  modport slave (
    output i_op, i_func_3, i_func_7_5, i_zero_flag, i_negative_flag,
           i_carry_flag, i_overflow_flag, i_mem_ready,
    input  o_alu_op, o_result_src, o_alu_src_1, o_alu_src_2, o_imm_src,
           o_mem_addr_src, o_mem_req, o_mem_write_en, o_instr_write_en,
           o_reg_write_en, o_pc_update, o_trap, o_trap_cause
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// RV32I multi-cycle controller: sequences fetch/decode/execute/memory/writeback over a shared ALU,
// with ready/valid memory waits, a per-access bus timeout and an illegal-instruction trap.
module multicycle_ctrl_fsm #(
  parameter bit          ENABLE_TRAP = 1'b1,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned TMO_W       = 8
) (
  input logic                  clk,
  input logic                  arstn,
  multicycle_ctrl_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADDR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECUTER,
    S_EXECUTEI, S_LUI, S_ALUWB, S_JALR, S_JAL, S_BRANCH, S_TRAP
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam bit              TMO_EN   = (TIMEOUT != 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [1:0]       cause_q, cause_d;

  logic [1:0] alu_op, result_src, alu_src_1, alu_src_2;
  logic [2:0] imm_src;
  logic       mem_addr_src, mem_req, mem_write_en, instr_write_en;
  logic       reg_write_en, pc_update, trap;
  logic       is_wait, wait_expired, taken;

  // funct7[5] only steers the ALU decoder in the datapath.
  logic unused_func_7_5;
  assign unused_func_7_5 = bus.i_func_7_5;

  assign wait_expired = TMO_EN && (tmo_q == TMO_LAST) && !bus.i_mem_ready;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d        = state_q;
    tmo_d          = '0;
    cause_d        = cause_q;
    alu_op         = 2'b00;
    result_src     = 2'b00;
    alu_src_1      = 2'b00;
    alu_src_2      = 2'b00;
    imm_src        = 3'b000;
    mem_addr_src   = 1'b0;
    mem_req        = 1'b0;
    mem_write_en   = 1'b0;
    instr_write_en = 1'b0;
    reg_write_en   = 1'b0;
    pc_update      = 1'b0;
    trap           = 1'b0;
    is_wait        = 1'b0;
    taken          = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        is_wait = 1'b1;
        if (bus.i_mem_ready) begin
          instr_write_en = 1'b1;
          pc_update      = 1'b1;
          alu_src_2      = 2'b10;
          result_src     = 2'b10;
          state_d        = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculatively form oldPC+imm so BRANCH/AUIPC find their target in ALUOut.
        alu_src_1 = 2'b01;
        alu_src_2 = 2'b01;
        unique case (bus.i_op)
          OP_LOAD, OP_STORE: state_d = S_MEMADDR;
          OP_OPIMM:          state_d = S_EXECUTEI;
          OP_OP:             state_d = S_EXECUTER;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_ALUWB;
          default: begin
            state_d = ENABLE_TRAP ? S_TRAP : S_FETCH;
            if (ENABLE_TRAP) cause_d = CAUSE_ILLEGAL;
          end
        endcase
        unique case (bus.i_op)
          OP_STORE:         imm_src = 3'b001;
          OP_BRANCH:        imm_src = 3'b010;
          OP_JAL:           imm_src = 3'b011;
          OP_LUI, OP_AUIPC: imm_src = 3'b100;
          default:          imm_src = 3'b000;
        endcase
      end
      S_MEMADDR: begin
        alu_src_1 = 2'b10;
        alu_src_2 = 2'b01;
        imm_src   = bus.i_op[5] ? 3'b001 : 3'b000;
        state_d   = bus.i_op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req      = 1'b1;
        mem_addr_src = 1'b1;
        is_wait      = 1'b1;
        if (bus.i_mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src   = 2'b01;
        reg_write_en = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req      = 1'b1;
        mem_write_en = 1'b1;
        mem_addr_src = 1'b1;
        is_wait      = 1'b1;
        if (bus.i_mem_ready) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_1 = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_1 = 2'b10;
        alu_src_2 = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_LUI: begin
        alu_src_1 = 2'b11;
        alu_src_2 = 2'b01;
        imm_src   = 3'b100;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_en = 1'b1;
        state_d      = S_FETCH;
      end
      S_JALR: begin
        alu_src_1 = 2'b10;
        alu_src_2 = 2'b01;
        state_d   = S_JAL;
      end
      S_JAL: begin
        // Jump to the target held in ALUOut while computing the link value oldPC+4.
        pc_update = 1'b1;
        alu_src_1 = 2'b01;
        alu_src_2 = 2'b10;
        state_d   = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_1 = 2'b10;
        alu_op    = 2'b01;
        unique case (bus.i_func_3)
          3'b000:  taken = bus.i_zero_flag;
          3'b001:  taken = !bus.i_zero_flag;
          3'b100:  taken = bus.i_negative_flag ^ bus.i_overflow_flag;
          3'b101:  taken = !(bus.i_negative_flag ^ bus.i_overflow_flag);
          3'b110:  taken = !bus.i_carry_flag;
          3'b111:  taken = bus.i_carry_flag;
          default: taken = 1'b0;
        endcase
        pc_update = taken;
        state_d   = S_FETCH;
        if (bus.i_func_3[2:1] == 2'b01 && ENABLE_TRAP) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_TRAP: begin
        trap       = 1'b1;
        result_src = 2'b11;
        pc_update  = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Shared wait handling: a ready in the expiring cycle still completes the access.
    if (is_wait && !bus.i_mem_ready) begin
      if (wait_expired) begin
        state_d = S_TRAP;
        cause_d = CAUSE_TIMEOUT;
      end else if (TMO_EN) begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= S_FETCH;
      tmo_q   <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      cause_q <= cause_d;
    end
  end

  assign bus.o_alu_op         = alu_op;
  assign bus.o_result_src     = result_src;
  assign bus.o_alu_src_1      = alu_src_1;
  assign bus.o_alu_src_2      = alu_src_2;
  assign bus.o_imm_src        = imm_src;
  assign bus.o_mem_addr_src   = mem_addr_src;
  assign bus.o_mem_req        = mem_req;
  assign bus.o_mem_write_en   = mem_write_en;
  assign bus.o_instr_write_en = instr_write_en;
  assign bus.o_reg_write_en   = reg_write_en;
  assign bus.o_pc_update      = pc_update;
  assign bus.o_trap           = trap;
  assign bus.o_trap_cause     = cause_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: one trapping instance with a short timeout and one
// instance with traps and timeout disabled; every control word is compared against hand values.
module tb_multicycle_ctrl_fsm;

  logic clk = 1'b0;
  logic arstn;
  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if if0 ();
  multicycle_ctrl_fsm_if if1 ();

  multicycle_ctrl_fsm #(.ENABLE_TRAP(1'b1), .TIMEOUT(4), .TMO_W(8)) dut0 (
    .clk(clk), .arstn(arstn), .bus(if0)
  );
  multicycle_ctrl_fsm #(.ENABLE_TRAP(1'b0), .TIMEOUT(0), .TMO_W(8)) dut1 (
    .clk(clk), .arstn(arstn), .bus(if1)
  );

  logic [17:0] ctrl0, ctrl1;
  assign ctrl0 = {if0.o_alu_op, if0.o_result_src, if0.o_alu_src_1, if0.o_alu_src_2, if0.o_imm_src,
                  if0.o_mem_addr_src, if0.o_mem_req, if0.o_mem_write_en, if0.o_instr_write_en,
                  if0.o_reg_write_en, if0.o_pc_update, if0.o_trap};
  assign ctrl1 = {if1.o_alu_op, if1.o_result_src, if1.o_alu_src_1, if1.o_alu_src_2, if1.o_imm_src,
                  if1.o_mem_addr_src, if1.o_mem_req, if1.o_mem_write_en, if1.o_instr_write_en,
                  if1.o_reg_write_en, if1.o_pc_update, if1.o_trap};

  int total = 0;
  int bad   = 0;
  logic [1:0] exp_cause0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Control word: alu_op, result_src, src1, src2, imm_src, addr_src, req, we, instr_we, reg_we, pc_upd, trap
  function automatic logic [17:0] mk(input logic [1:0] alu, input logic [1:0] res, input logic [1:0] s1,
                                     input logic [1:0] s2, input logic [2:0] imm, input logic addr,
                                     input logic req, input logic we, input logic iw, input logic rw,
                                     input logic pc, input logic tr);
    return {alu, res, s1, s2, imm, addr, req, we, iw, rw, pc, tr};
  endfunction

  function automatic logic [17:0] dec(input logic [2:0] imm);
    return mk(2'b00, 2'b00, 2'b01, 2'b01, imm, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  logic [17:0] v_fwait, v_frdy, v_aluwb, v_trap, v_mrd, v_mwr, v_jal;

  // Inputs are driven just after a rising edge; outputs are compared on the following falling edge.
  task automatic cyc(input string tag, input logic [17:0] exp, input bit sel = 1'b0);
    @(negedge clk);
    check(tag, sel ? ctrl1 : ctrl0, exp);
    check($sformatf("%s.cause", tag), sel ? if1.o_trap_cause : if0.o_trap_cause,
          sel ? 2'b00 : exp_cause0);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0] f3;
    logic z, n, c, v, taken;
  } br_t;

  br_t br_tab[8] = '{
    '{3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1},  // BLT  N^V=1
    '{3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0},  // BLT  N^V=0
    '{3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1},  // BEQ  Z=1
    '{3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},  // BNE  Z=1
    '{3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},  // BGE  N^V=0
    '{3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},  // BLTU C=1
    '{3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1},  // BGEU C=1
    '{3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}   // BLTU C=0
  };

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    v_fwait = mk(2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    v_frdy  = mk(2'b00, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    v_aluwb = mk(2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    v_trap  = mk(2'b00, 2'b11, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    v_mrd   = mk(2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    v_mwr   = mk(2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    v_jal   = mk(2'b00, 2'b00, 2'b01, 2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_cause0 = 2'b00;

    arstn = 1'b0;
    if0.i_op = 7'b0010011; if0.i_func_3 = 3'b000; if0.i_func_7_5 = 1'b0;
    if0.i_zero_flag = 1'b0; if0.i_negative_flag = 1'b0; if0.i_carry_flag = 1'b0;
    if0.i_overflow_flag = 1'b0; if0.i_mem_ready = 1'b0;
    if1.i_op = 7'b1111111; if1.i_func_3 = 3'b000; if1.i_func_7_5 = 1'b0;
    if1.i_zero_flag = 1'b0; if1.i_negative_flag = 1'b0; if1.i_carry_flag = 1'b0;
    if1.i_overflow_flag = 1'b0; if1.i_mem_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst.ctrl", ctrl0, v_fwait);
    check("rst.cause", if0.o_trap_cause, 2'b00);
    arstn = 1'b1;
    if0.i_mem_ready = 1'b1;

    // ADDI
    cyc("addi.fetch", v_frdy);
    cyc("addi.dec", dec(3'b000));
    cyc("addi.exe", mk(2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc("addi.wb", v_aluwb);

    // LW with three stalled MEMREAD cycles; ready arrives in the last counter slot before expiry
    if0.i_op = 7'b0000011;
    cyc("lw.fetch", v_frdy);
    cyc("lw.dec", dec(3'b000));
    cyc("lw.addr", mk(2'b00, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    if0.i_mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc($sformatf("lw.wait%0d", i), v_mrd);
    if0.i_mem_ready = 1'b1;
    cyc("lw.rdy", v_mrd);
    cyc("lw.wb", mk(2'b00, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));

    // SW
    if0.i_op = 7'b0100011;
    cyc("sw.fetch", v_frdy);
    cyc("sw.dec", dec(3'b001));
    cyc("sw.addr", mk(2'b00, 2'b00, 2'b10, 2'b01, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc("sw.mw", v_mwr);

    // Branches
    if0.i_op = 7'b1100011;
    for (int i = 0; i < 8; i++) begin
      if0.i_func_3 = br_tab[i].f3;
      if0.i_zero_flag = br_tab[i].z; if0.i_negative_flag = br_tab[i].n;
      if0.i_carry_flag = br_tab[i].c; if0.i_overflow_flag = br_tab[i].v;
      cyc($sformatf("br%0d.fetch", i), v_frdy);
      cyc($sformatf("br%0d.dec", i), dec(3'b010));
      cyc($sformatf("br%0d.exe", i),
          mk(2'b01, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, br_tab[i].taken, 1'b0));
    end

    // Illegal branch funct3 traps with cause 01
    if0.i_func_3 = 3'b010;
    if0.i_zero_flag = 1'b0; if0.i_negative_flag = 1'b0; if0.i_carry_flag = 1'b0;
    if0.i_overflow_flag = 1'b0;
    cyc("bill.fetch", v_frdy);
    cyc("bill.dec", dec(3'b010));
    cyc("bill.exe", mk(2'b01, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_cause0 = 2'b01;
    cyc("bill.trap", v_trap);
    if0.i_func_3 = 3'b000;

    // FETCH timeout: four waits, TRAP on the fifth cycle
    if0.i_mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) cyc($sformatf("ftmo.wait%0d", i), v_fwait);
    exp_cause0 = 2'b10;
    cyc("ftmo.trap", v_trap);

    // Illegal opcode
    if0.i_mem_ready = 1'b1;
    if0.i_op = 7'b1111111;
    cyc("ill.fetch", v_frdy);
    cyc("ill.dec", dec(3'b000));
    exp_cause0 = 2'b01;
    cyc("ill.trap", v_trap);

    // JALR
    if0.i_op = 7'b1100111;
    cyc("jalr.fetch", v_frdy);
    cyc("jalr.dec", dec(3'b000));
    cyc("jalr.exe", mk(2'b00, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc("jalr.jal", v_jal);
    cyc("jalr.wb", v_aluwb);

    // JAL
    if0.i_op = 7'b1101111;
    cyc("jal.fetch", v_frdy);
    cyc("jal.dec", dec(3'b011));
    cyc("jal.jal", v_jal);
    cyc("jal.wb", v_aluwb);

    // LUI
    if0.i_op = 7'b0110111;
    cyc("lui.fetch", v_frdy);
    cyc("lui.dec", dec(3'b100));
    cyc("lui.exe", mk(2'b00, 2'b00, 2'b11, 2'b01, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc("lui.wb", v_aluwb);

    // AUIPC
    if0.i_op = 7'b0010111;
    cyc("auipc.fetch", v_frdy);
    cyc("auipc.dec", dec(3'b100));
    cyc("auipc.wb", v_aluwb);

    // R-type
    if0.i_op = 7'b0110011;
    cyc("r.fetch", v_frdy);
    cyc("r.dec", dec(3'b000));
    cyc("r.exe", mk(2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc("r.wb", v_aluwb);

    // Store timeout in MEMWRITE
    if0.i_op = 7'b0100011;
    cyc("swtmo.fetch", v_frdy);
    cyc("swtmo.dec", dec(3'b001));
    cyc("swtmo.addr", mk(2'b00, 2'b00, 2'b10, 2'b01, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    if0.i_mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) cyc($sformatf("swtmo.wait%0d", i), v_mwr);
    exp_cause0 = 2'b10;
    cyc("swtmo.trap", v_trap);

    // Asynchronous reset while a store is waiting
    if0.i_mem_ready = 1'b1;
    cyc("rstw.fetch", v_frdy);
    cyc("rstw.dec", dec(3'b001));
    cyc("rstw.addr", mk(2'b00, 2'b00, 2'b10, 2'b01, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    if0.i_mem_ready = 1'b0;
    cyc("rstw.mw", v_mwr);
    arstn = 1'b0;
    #1;
    check("rstw.ctrl", ctrl0, v_fwait);
    check("rstw.cause", if0.o_trap_cause, 2'b00);
    exp_cause0 = 2'b00;
    @(posedge clk);
    #1;
    arstn = 1'b1;
    if0.i_mem_ready = 1'b1;
    if0.i_op = 7'b0010011;
    cyc("post.fetch", v_frdy);
    cyc("post.dec", dec(3'b000));

    // Second instance: no timeout ever, illegal opcode retired as a NOP
    cyc("nt.wait", v_fwait, 1'b1);
    if1.i_mem_ready = 1'b1;
    cyc("nt.fetch", v_frdy, 1'b1);
    cyc("nt.dec", dec(3'b000), 1'b1);
    cyc("nt.refetch", v_frdy, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
